// File: rtl/operand_entry.sv
// -----------------------------------------------------------------------------
// operand_entry
//
// Front end for the arithmetic LED demo. It takes raw slide switches and a
// bouncy push-button. It sequences entry of operand A, operand B and the
// operation select. The resulting registered set goes to the arithmetic /
// LED-mux top level with a valid flag.
//
// Ports:
//   clk    in   1   system clock, all state on rising edge
//   rst    in   1   asynchronous, active-high reset
//   sw     in   W   raw slide switches (asynchronous to clk)
//   btn    in   1   raw push-button, active-high, bouncy, asynchronous
//   A      out  W   registered operand A
//   B      out  W   registered operand B
//   ctrl   out  W   registered operation select
//   valid  out  1   high only while A/B/ctrl form a complete, stable set
//   stage  out  4   one-hot entry stage {SHOW, ENTER_OP, ENTER_B, ENTER_A}
// -----------------------------------------------------------------------------
module operand_entry #(
  parameter int DB_CYCLES = 1000000,
  parameter int W         = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sw,
  input  logic         btn,
  output logic [W-1:0] A,
  output logic [W-1:0] B,
  output logic [W-1:0] ctrl,
  output logic         valid,
  output logic [3:0]   stage
);

  // The counter only has to reach DB_CYCLES-1.
  localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  // The state encoding is the one-hot stage pattern, so stage is the state
  // register itself.
  typedef enum logic [3:0] {
    ST_ENTER_A  = 4'b0001,
    ST_ENTER_B  = 4'b0010,
    ST_ENTER_OP = 4'b0100,
    ST_SHOW     = 4'b1000
  } state_t;

  logic [W-1:0]     sw_meta_q, sw_s_q;
  logic             btn_meta_q, btn_s_q;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             db_level_q, db_level_d;
  logic             db_level_dly_q;
  logic             press_s;
  state_t           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     ctrl_q, ctrl_d;
  logic             valid_q, valid_d;

  // Two-flop synchronisers for the asynchronous switch and button inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta_q  <= {W{1'b0}};
      sw_s_q     <= {W{1'b0}};
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
    end else begin
      sw_meta_q  <= sw;
      sw_s_q     <= sw_meta_q;
      btn_meta_q <= btn;
      btn_s_q    <= btn_meta_q;
    end
  end

  // Debounce next state. A level change is accepted only after DB_CYCLES
  // consecutive mismatched cycles. Any matching cycle restarts the count.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    if (btn_s_q != db_level_q) begin
      if (db_cnt_q == CNT_MAX) begin
        db_level_d = ~db_level_q;
        db_cnt_d   = {CNT_W{1'b0}};
      end else begin
        db_cnt_d   = db_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      db_cnt_d = {CNT_W{1'b0}};
    end
  end

  // Debounce counter, debounced level and its one-cycle delayed copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q       <= {CNT_W{1'b0}};
      db_level_q     <= 1'b0;
      db_level_dly_q <= 1'b0;
    end else begin
      db_cnt_q       <= db_cnt_d;
      db_level_q     <= db_level_d;
      db_level_dly_q <= db_level_q;
    end
  end

  // Rising edge of the debounced level. Release produces no event.
  assign press_s = db_level_q & ~db_level_dly_q;

  // Entry FSM next state and capture logic. Each operand register is written
  // only from its own stage, and only on the press cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    case (state_q)
      ST_ENTER_A: begin
        if (press_s) begin
          a_d     = sw_s_q;
          state_d = ST_ENTER_B;
        end else begin
          state_d = ST_ENTER_A;
        end
      end
      ST_ENTER_B: begin
        if (press_s) begin
          b_d     = sw_s_q;
          state_d = ST_ENTER_OP;
        end else begin
          state_d = ST_ENTER_B;
        end
      end
      ST_ENTER_OP: begin
        // valid rises on the same edge as the ctrl capture.
        if (press_s) begin
          ctrl_d  = sw_s_q;
          valid_d = 1'b1;
          state_d = ST_SHOW;
        end else begin
          state_d = ST_ENTER_OP;
        end
      end
      ST_SHOW: begin
        if (press_s) begin
          valid_d = 1'b0;
          state_d = ST_ENTER_A;
        end else begin
          state_d = ST_SHOW;
        end
      end
      default: begin
        // Illegal encodings recover to the start of entry.
        valid_d = 1'b0;
        state_d = ST_ENTER_A;
      end
    endcase
  end

  // FSM state and captured operand registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ENTER_A;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      ctrl_q  <= {W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign A     = a_q;
  assign B     = b_q;
  assign ctrl  = ctrl_q;
  assign valid = valid_q;
  assign stage = state_q;

endmodule

// File: doc/operand_entry.md
Name: operand_entry

Overview:
Input-side front end for the arithmetic LED demo. It takes raw board switches and one push-button and sequences entry of operand A, operand B and the operation select. It then presents the registered A, B and ctrl values, with a valid flag, to the arithmetic/LED-mux top level. It includes switch synchronisation, button debounce, press-edge detection and the entry state machine.

Parameters:
DB_CYCLES, 1000000, consecutive synchronised-button cycles needed to accept a level change (10 ms at 100 MHz; benches use 4)
W, 3, width of the switch bus and of each of A, B, ctrl

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
sw  input  W  raw slide switches, asynchronous to clk
btn  input  1  raw push-button, active-high, bouncy, asynchronous
A  output  W  registered operand A
B  output  W  registered operand B
ctrl  output  W  registered operation select (0 add, 1 sub, 2 mult, 3 div, 4 mod, others give a zero result downstream)
valid  output  1  high while A, B and ctrl form a complete, stable set
stage  output  4  one-hot entry stage for status LEDs: bit0 = ENTER_A, bit1 = ENTER_B, bit2 = ENTER_OP, bit3 = SHOW

Behaviour:
- Reset: rst high forces immediately (asynchronously) A=0, B=0, ctrl=0, valid=0, stage=4'b0001, FSM=ENTER_A, debounce counter=0, debounced level=0, edge register=0, synchroniser flops=0. Reset mid-entry discards the partial entry.
- Synchronisers: sw and btn each pass through 2 flops (sw_s, btn_s). No other logic uses the raw inputs.
- Debounce:
  - Counter increments each cycle btn_s != db_level.
  - Counter clears to 0 on any cycle btn_s == db_level.
  - When the counter reaches DB_CYCLES-1 while still mismatched, db_level toggles and the counter clears on that same edge.
  - A glitch shorter than DB_CYCLES cycles never changes db_level.
- Press pulse:
  - press = db_level & ~db_level_d, where db_level_d is db_level delayed 1 cycle.
  - press is one cycle wide, one per accepted press. Release generates no event.
  - A held button produces exactly one press.
- Latency: btn steady high from cycle 0 gives btn_s high at cycle 2, db_level high at cycle 2+DB_CYCLES, press high that same cycle, and the captured register visible at cycle 3+DB_CYCLES.
- FSM (advances only on press; otherwise holds):
  - ENTER_A: on press, A <= sw_s, go to ENTER_B.
  - ENTER_B: on press, B <= sw_s, go to ENTER_OP.
  - ENTER_OP: on press, ctrl <= sw_s, valid <= 1, go to SHOW.
  - SHOW: on press, valid <= 0, go to ENTER_A. A, B and ctrl hold their old values until overwritten.
- Capture rules:
  - The captured value is sw_s on the press cycle. Switch movement at any other time has no effect on A, B or ctrl.
  - A is written only in ENTER_A, B only in ENTER_B, ctrl only in ENTER_OP.
- valid: 0 in ENTER_A, ENTER_B and ENTER_OP; 1 only in SHOW. It rises on the same edge as the ctrl capture, so A, B and ctrl are never mid-update while valid=1.
- stage: registered, one-hot, always matches the FSM state. It never holds 0 or more than one set bit; unreachable encodings recover to ENTER_A.
- No arithmetic is performed here; widths pass through unchanged (W bits).

Test Plan:
- Reset: assert rst asynchronously mid-cycle with sw=3'b111 and btn bouncing -> A=B=ctrl=0, valid=0, stage=0001 immediately; all remain so after release until a debounced press.
- Full entry (DB_CYCLES=4), clean presses:
  - sw=3 press -> A=3, stage=0010.
  - sw=5 press -> B=5, stage=0100.
  - sw=2 press -> ctrl=2, valid=1, stage=1000.
  - Fourth press -> valid=0, stage=0001, A/B/ctrl still 3/5/2.
- Bounce rejection: btn toggles high 3 cycles, low 1, high 2, low 2, then steady high -> exactly one press, issued 4 cycles after the steady-high sync; stage advances by one only.
- Held button: btn held high 50 cycles in ENTER_A -> one capture only, stage=0010; release followed by 10 cycles low produces no event.
- Switch timing: in ENTER_B, change sw from 6 to 1 two cycles after press -> B=6. Change sw from 1 to 4 five cycles before the next press -> ctrl=4.
- Reset mid-entry: in ENTER_OP with A=7, B=2, assert rst -> A=B=0, stage=0001, valid=0; next press with sw=1 gives A=1.
